median_window_ctrl: RTL and testbench

MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

---
 rtl/median_window_ctrl_pkg.sv | 20 ++
 rtl/median_line_buf.sv | 31 +++
 rtl/median_sort9.sv | 38 +++
 rtl/median_window_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_median_window_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/median_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : median_window_ctrl_pkg
// Brief    : Shared FSM encoding and counter width for the 3x3 median block.
// Revision : 1.0
// ============================================================================
package median_window_ctrl_pkg;

   localparam int CNT_W = 12;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage : median_window_ctrl_pkg
`default_nettype wire

// File: rtl/median_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : median_line_buf
// Brief    : Single-port line buffer, combinational read before clocked write.
// Revision : 1.0
// ============================================================================
module median_line_buf #(
   parameter int DATA_SIZE = 8,
   parameter int DEPTH     = 640,
   parameter int AW        = 10
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [AW-1:0]        i_addr,
   input  logic [DATA_SIZE-1:0] i_wdata,
   output logic [DATA_SIZE-1:0] o_rdata
);

   // Contents are never reset; every entry is rewritten before it can matter.
   logic [DATA_SIZE-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule : median_line_buf
`default_nettype wire

// File: rtl/median_sort9.sv
`default_nettype none
// ============================================================================
// Module   : median_sort9
// Brief    : Combinational 19-exchange median-of-nine sort network.
// Revision : 1.0
// ============================================================================
module median_sort9 #(
   parameter int DATA_SIZE = 8
) (
   input  logic [8:0][DATA_SIZE-1:0] i_win,
   output logic [DATA_SIZE-1:0]      o_med
);

   localparam int c_PA [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
   localparam int c_PB [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

   logic [DATA_SIZE-1:0] w_p [9];
   logic [DATA_SIZE-1:0] w_t;

   // Each exchange leaves the smaller value at c_PA, the larger at c_PB.
   always_comb begin
      w_t = '0;
      for (int i = 0; i < 9; i++) begin
         w_p[i] = i_win[i];
      end
      for (int k = 0; k < 19; k++) begin
         if (w_p[c_PA[k]] > w_p[c_PB[k]]) begin
            w_t            = w_p[c_PA[k]];
            w_p[c_PA[k]]   = w_p[c_PB[k]];
            w_p[c_PB[k]]   = w_t;
         end
      end
   end

   assign o_med = w_p[4];

endmodule : median_sort9
`default_nettype wire

// File: rtl/median_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : median_window_ctrl
// Brief    : Raster-stream 3x3 median filter controller (valid-only windows).
// Revision : 1.0
// ============================================================================
module median_window_ctrl #(
   parameter int DATA_SIZE  = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 busy,
   output logic                 done
);

   import median_window_ctrl_pkg::*;

   localparam int              LB_AW      = $clog2(IMG_WIDTH);
   localparam logic [CNT_W-1:0] c_LAST_COL = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] c_LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] c_TWO      = CNT_W'(2);

   state_t                      r_state;
   logic [CNT_W-1:0]            r_col;
   logic [CNT_W-1:0]            r_row;
   logic [8:0][DATA_SIZE-1:0]   r_win;
   logic [8:0][DATA_SIZE-1:0]   w_win_nxt;
   logic                        r_out_valid;
   logic [DATA_SIZE-1:0]        r_out_data;
   logic                        r_busy;
   logic                        r_done;

   logic                        w_in_ready;
   logic                        w_accept;
   logic                        w_last_col;
   logic                        w_last_pix;
   logic                        w_fill_end;
   logic                        w_complete;
   logic [LB_AW-1:0]            w_lb_addr;
   logic [DATA_SIZE-1:0]        w_tap1;
   logic [DATA_SIZE-1:0]        w_tap2;
   logic [DATA_SIZE-1:0]        w_med;

   assign w_in_ready = ((r_state == S_FILL) || (r_state == S_RUN)) &&
                       (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_last_col = (r_col == c_LAST_COL);
   assign w_last_pix = w_last_col && (r_row == c_LAST_ROW);
   assign w_fill_end = (r_row == c_TWO) && (r_col == c_TWO);
   assign w_complete = w_accept && (r_row >= c_TWO) && (r_col >= c_TWO);
   assign w_lb_addr  = r_col[LB_AW-1:0];

   // Line buffer 1 holds row r-1; its old entry cascades into buffer 2 (row r-2).
   median_line_buf #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (IMG_WIDTH),
      .AW        (LB_AW)
   ) u_lb1 (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (w_lb_addr),
      .i_wdata (in_data),
      .o_rdata (w_tap1)
   );

   median_line_buf #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (IMG_WIDTH),
      .AW        (LB_AW)
   ) u_lb2 (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (w_lb_addr),
      .i_wdata (w_tap1),
      .o_rdata (w_tap2)
   );

   // Window index = row*3 + col; row 0 is the oldest line, col 2 the newest pixel.
   always_comb begin
      w_win_nxt = r_win;
      for (int r = 0; r < 3; r++) begin
         w_win_nxt[r*3]     = r_win[r*3 + 1];
         w_win_nxt[r*3 + 1] = r_win[r*3 + 2];
      end
      w_win_nxt[2] = w_tap2;
      w_win_nxt[5] = w_tap1;
      w_win_nxt[8] = in_data;
   end

   median_sort9 #(
      .DATA_SIZE (DATA_SIZE)
   ) u_sort (
      .i_win (w_win_nxt),
      .o_med (w_med)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_win       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_col <= '0;
            r_row <= '0;
         end else if (w_accept) begin
            r_win <= w_win_nxt;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= r_row + CNT_W'(1);
            end else begin
               r_col <= r_col + CNT_W'(1);
            end
         end
         // A new result may replace one being consumed in the same cycle.
         if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_med;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_FILL;
                  r_busy  <= 1'b1;
               end
            end
            S_FILL: begin
               if (w_accept && w_fill_end) begin
                  r_state <= w_last_pix ? S_FLUSH : S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept && w_last_pix) begin
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (!r_out_valid || out_ready) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule : median_window_ctrl
`default_nettype wire

// File: tb/tb_median_window_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_median_window_ctrl
// Brief    : Directed self-checking bench for median_window_ctrl (3 sizes).
// Revision : 1.0
// ============================================================================
module tb_median_window_ctrl;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0] start_v;
   logic [2:0] in_valid_v;
   logic [2:0] out_ready_v;
   logic [7:0] in_data_v [3];
   wire  [2:0] in_ready_v;
   wire  [2:0] out_valid_v;
   wire  [2:0] busy_v;
   wire  [2:0] done_v;
   wire  [7:0] out_data_v [3];

   median_window_ctrl #(.DATA_SIZE(8), .IMG_WIDTH(4), .IMG_HEIGHT(3)) u_4x3 (
      .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid_v[0]),
      .in_ready(in_ready_v[0]), .in_data(in_data_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .out_data(out_data_v[0]), .busy(busy_v[0]),
      .done(done_v[0]));

   median_window_ctrl #(.DATA_SIZE(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) u_8x8 (
      .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid_v[1]),
      .in_ready(in_ready_v[1]), .in_data(in_data_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .out_data(out_data_v[1]), .busy(busy_v[1]),
      .done(done_v[1]));

   median_window_ctrl #(.DATA_SIZE(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_5x5 (
      .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid_v[2]),
      .in_ready(in_ready_v[2]), .in_data(in_data_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .out_data(out_data_v[2]), .busy(busy_v[2]),
      .done(done_v[2]));

   int pix [64];
   int got [$];
   int expq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int med9(input int a [9]);
      int s [9];
      int t;
      s = a;
      for (int i = 1; i < 9; i++) begin
         for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
            t = s[j]; s[j] = s[j-1]; s[j-1] = t;
         end
      end
      return s[4];
   endfunction

   task automatic build_exp(input int w, input int h);
      int a [9];
      expq.delete();
      for (int r = 2; r < h; r++) begin
         for (int c = 2; c < w; c++) begin
            for (int dr = 0; dr < 3; dr++) begin
               for (int dc = 0; dc < 3; dc++) begin
                  a[dr*3 + dc] = pix[(r - dr) * w + (c - dc)];
               end
            end
            expq.push_back(med9(a));
         end
      end
   endtask

   // Streams one frame into instance k; optional stall, in-frame start pulse, abort.
   task automatic run_frame(input int k, input int w, input int h, input int stall_at,
                            input int start_at, input int abort_at, output bit aborted);
      int p, total, stall_left, cyc;
      bit fin, stall_started, start_done;
      logic [7:0] held;
      got.delete();
      total = w * h; p = 0; stall_left = 0; cyc = 0; held = '0;
      fin = 1'b0; stall_started = 1'b0; start_done = 1'b0; aborted = 1'b0;
      @(negedge clk); start_v[k] = 1'b1;
      @(negedge clk); start_v[k] = 1'b0;
      chk("busy_after_start", busy_v[k], 1);
      while (!fin && cyc < 3000) begin
         if (!stall_started && stall_at >= 0 && p == stall_at) begin
            stall_started = 1'b1;
            stall_left    = 10;
         end
         out_ready_v[k] = (stall_left == 0);
         start_v[k]     = (start_at >= 0 && !start_done && p == start_at);
         if (start_v[k]) start_done = 1'b1;
         in_valid_v[k]  = (p < total);
         in_data_v[k]   = (p < total) ? 8'(pix[p]) : 8'd0;
         #1;
         if (abort_at >= 0 && p == abort_at) begin
            aborted = 1'b1;
            fin     = 1'b1;
         end else begin
            if (stall_left > 0) begin
               chk("stall_out_valid", out_valid_v[k], 1);
               chk("stall_in_ready", in_ready_v[k], 0);
               if (stall_left == 10) held = out_data_v[k];
               else chk("stall_hold", out_data_v[k], held);
               stall_left--;
            end
            if (in_valid_v[k] && in_ready_v[k]) p++;
            if (out_valid_v[k] && out_ready_v[k]) got.push_back(int'(out_data_v[k]));
            if (done_v[k]) begin
               chk("done_busy_high", busy_v[k], 1);
               @(negedge clk);
               chk("done_one_cycle", done_v[k], 0);
               chk("busy_fall", busy_v[k], 0);
               fin = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
         cyc++;
      end
      start_v[k] = 1'b0;
      if (!aborted) begin
         in_valid_v[k]  = 1'b0;
         out_ready_v[k] = 1'b1;
         chk("frame_completed", fin, 1);
      end
   endtask

   task automatic check_results(input string tag);
      chk({tag, "_count"}, got.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         chk(tag, (i < got.size()) ? got[i] : -1, expq[i]);
      end
   endtask

   initial begin
      bit ab;
      int bad;
      rst         = 1'b0;
      start_v     = '0;
      in_valid_v  = '0;
      out_ready_v = '1;
      for (int i = 0; i < 3; i++) in_data_v[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid_v[0], 0);
      chk("rst_out_data", out_data_v[0], 0);
      chk("rst_busy", busy_v[0], 0);
      chk("rst_done", done_v[0], 0);
      chk("rst_in_ready", in_ready_v[0], 0);
      rst = 1'b1;
      @(negedge clk);

      // 4x3 ramp: windows median 5 then 6
      for (int i = 0; i < 12; i++) pix[i] = i;
      run_frame(0, 4, 3, -1, -1, -1, ab);
      chk("t1_count", got.size(), 2);
      chk("t1_res0", (got.size() > 0) ? got[0] : -1, 5);
      chk("t1_res1", (got.size() > 1) ? got[1] : -1, 6);

      // 8x8 flat field of 5
      for (int i = 0; i < 64; i++) pix[i] = 5;
      run_frame(1, 8, 8, -1, -1, -1, ab);
      chk("t2_count", got.size(), 36);
      bad = 0;
      foreach (got[i]) if (got[i] != 5) bad++;
      chk("t2_all_five", bad, 0);

      // 5x5 impulse at (2,2)
      for (int i = 0; i < 25; i++) pix[i] = 0;
      pix[2*5 + 2] = 255;
      run_frame(2, 5, 5, -1, -1, -1, ab);
      chk("t3_count", got.size(), 9);
      bad = 0;
      foreach (got[i]) if (got[i] != 0) bad++;
      chk("t3_all_zero", bad, 0);

      // 8x8 textured frame, back-pressure at pixel 30, stray start at pixel 40
      for (int i = 0; i < 64; i++) pix[i] = (i * 37 + 11) % 256;
      build_exp(8, 8);
      run_frame(1, 8, 8, 30, 40, -1, ab);
      check_results("t4_res");

      // Reset at row 3 col 7, then a fresh frame
      run_frame(1, 8, 8, -1, -1, 3*8 + 7, ab);
      chk("t5_aborted", ab, 1);
      rst = 1'b0;
      #1;
      chk("t5_rst_out_valid", out_valid_v[1], 0);
      chk("t5_rst_out_data", out_data_v[1], 0);
      chk("t5_rst_busy", busy_v[1], 0);
      chk("t5_rst_done", done_v[1], 0);
      chk("t5_rst_in_ready", in_ready_v[1], 0);
      @(posedge clk); #1;
      chk("t5_idle_busy", busy_v[1], 0);
      @(negedge clk);
      rst            = 1'b1;
      in_valid_v[1]  = 1'b0;
      out_ready_v[1] = 1'b1;
      @(negedge clk);
      chk("t5_no_autostart", busy_v[1], 0);
      for (int i = 0; i < 64; i++) pix[i] = (i * i * 13 + 5) % 256;
      build_exp(8, 8);
      run_frame(1, 8, 8, -1, -1, -1, ab);
      check_results("t5_res");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_median_window_ctrl
`default_nettype wire
